patch_gen_3_3: RTL and testbench

- Producer side of the 3x3 patch interface consumed by conv_3_3.
- Accepts a raster-order pixel stream (row-major, one pixel per beat) and emits every fully-populated 3x3 window as a packed PATCH word, with valid/ready handshakes on both sides.
- Two internal line buffers plus a 3x3 window register file; valid windows only, no padding. A frame of IMG_W x IMG_H pixels yields (IMG_W-2)*(IMG_H-2) patches.

---
 rtl/patch_gen_3_3.sv | 114 +++++++++++
 tb/tb_patch_gen_3_3.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/patch_gen_3_3.sv
// patch_gen_3_3: raster pixel stream in, every valid 3x3 window out.
// Two line buffers feed a shifting window; one registered output stage.
module patch_gen_3_3 #(
   parameter int DW    = 16,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic            CLK,
   input  logic            rst,
   input  logic [DW-1:0]   PIX,
   input  logic            pix_valid,
   output logic            pix_ready,
   output logic [9*DW-1:0] PATCH,
   output logic            patch_valid,
   input  logic            patch_ready,
   output logic            patch_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [DW-1:0]   lb1_q [IMG_W];
   logic [DW-1:0]   lb2_q [IMG_W];
   logic [DW-1:0]   win_q [3][3];
   logic [DW-1:0]   win_d [3][3];
   logic [9*DW-1:0] patch_q, patch_d;
   logic            valid_q, valid_d;
   logic            last_q, last_d;
   logic            acc, xfer, emit;
   logic            col_end, row_end;
   logic [DW-1:0]   up2, up1;

   always_comb begin
      pix_ready = !rst && (!valid_q || patch_ready);
      acc       = pix_valid && pix_ready;
      xfer      = valid_q && patch_ready;
      col_end   = (col_q == CW'(IMG_W - 1));
      row_end   = (row_q == RW'(IMG_H - 1));
      emit      = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));
      up2       = lb2_q[col_q];
      up1       = lb1_q[col_q];
   end

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      patch_d = patch_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (acc) begin
         col_d = col_end ? '0 : col_q + 1'b1;
         if (col_end) begin
            row_d = row_end ? '0 : row_q + 1'b1;
         end
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         // new right column comes from the pre-update buffers
         win_d[0][2] = up2;
         win_d[1][2] = up1;
         win_d[2][2] = PIX;
      end
      if (emit) begin
         patch_d = {win_d[0][0], win_d[0][1], win_d[0][2],
                    win_d[1][0], win_d[1][1], win_d[1][2],
                    win_d[2][0], win_d[2][1], win_d[2][2]};
         valid_d = 1'b1;
         last_d  = row_end && col_end;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         patch_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         patch_q <= patch_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         win_q   <= win_d;
      end
   end

   // buffer contents are overwritten by rows 0/1 before any emit
   always_ff @(posedge CLK) begin
      if (acc) begin
         lb2_q[col_q] <= lb1_q[col_q];
         lb1_q[col_q] <= PIX;
      end
   end

   always_comb begin
      PATCH       = rst ? '0 : patch_q;
      patch_valid = valid_q && !rst;
      patch_last  = last_q && !rst;
   end

endmodule

// File: tb/tb_patch_gen_3_3.sv
// tb_patch_gen_3_3: directed checks of patch_gen_3_3 on 4x4 and 8x8 frames.
module tb_patch_gen_3_3;

   localparam int DW = 16;
   localparam int PW = 9 * DW;

   logic          CLK = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] PIX = '0;
   logic          pix_valid = 1'b0;
   logic          patch_ready = 1'b0;
   logic          use8 = 1'b0;
   logic          rnd_rdy = 1'b0;
   logic          gap_en = 1'b0;

   logic          pr4, pv4, pl4, pr8, pv8, pl8;
   logic [PW-1:0] pch4, pch8;
   logic          rdy, pvs, pls;
   logic [PW-1:0] pchs;

   logic [PW-1:0] qp [$];
   logic          ql [$];
   logic [PW-1:0] e [4];
   int            n_chk = 0;
   int            n_err = 0;

   always #5 CLK = ~CLK;

   patch_gen_3_3 #(.DW(DW), .IMG_W(4), .IMG_H(4)) u4 (
      .CLK(CLK), .rst(rst), .PIX(PIX), .pix_valid(pix_valid),
      .pix_ready(pr4), .PATCH(pch4), .patch_valid(pv4),
      .patch_ready(patch_ready), .patch_last(pl4)
   );

   patch_gen_3_3 #(.DW(DW), .IMG_W(8), .IMG_H(8)) u8 (
      .CLK(CLK), .rst(rst), .PIX(PIX), .pix_valid(pix_valid),
      .pix_ready(pr8), .PATCH(pch8), .patch_valid(pv8),
      .patch_ready(patch_ready), .patch_last(pl8)
   );

   assign rdy  = use8 ? pr8 : pr4;
   assign pvs  = use8 ? pv8 : pv4;
   assign pls  = use8 ? pl8 : pl4;
   assign pchs = use8 ? pch8 : pch4;

   always @(negedge CLK) begin
      if (pvs && patch_ready) begin
         qp.push_back(pchs);
         ql.push_back(pls);
      end
   end

   task automatic chk(input string tag, input logic [PW-1:0] got,
                      input logic [PW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] pk9(int a0, int a1, int a2, int a3,
                                          int a4, int a5, int a6, int a7,
                                          int a8);
      return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4),
              DW'(a5), DW'(a6), DW'(a7), DW'(a8)};
   endfunction

   function automatic logic [PW-1:0] refp(int r, int c, int base,
                                           int stride);
      logic [PW-1:0] p = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            p = {p[PW-DW-1:0], DW'(base + (r - 1 + i) * stride + (c - 1 + j))};
         end
      end
      return p;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
      if (rnd_rdy) patch_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input int v);
      int t;
      if (gap_en) begin
         while ($urandom_range(0, 1) == 1) begin
            pix_valid = 1'b0;
            tick();
         end
      end
      PIX = DW'(v);
      pix_valid = 1'b1;
      t = 0;
      forever begin
         @(negedge CLK);
         if (rdy) break;
         tick();
         t++;
         if (t > 300) begin
            chk("push_timeout", 0, 1);
            break;
         end
      end
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic send_frame(input int w, input int h, input int base,
                             input int stride);
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            push(base + r * stride + c);
         end
      end
   endtask

   task automatic drain(input int n);
      int t = 0;
      while (qp.size() < n && t < 500) begin
         tick();
         t++;
      end
      repeat (3) tick();
      chk("npatch", qp.size(), n);
   endtask

   task automatic check_hand4(input string tag);
      for (int k = 0; k < 4 && k < qp.size(); k++) begin
         chk({tag, "_patch"}, qp[k], e[k]);
         chk({tag, "_last"}, ql[k], (k == 3));
      end
      qp.delete();
      ql.delete();
   endtask

   initial begin
      e[0] = pk9(0, 1, 2, 4, 5, 6, 8, 9, 10);
      e[1] = pk9(1, 2, 3, 5, 6, 7, 9, 10, 11);
      e[2] = pk9(4, 5, 6, 8, 9, 10, 12, 13, 14);
      e[3] = pk9(5, 6, 7, 9, 10, 11, 13, 14, 15);

      // reset state
      repeat (2) tick();
      @(negedge CLK);
      chk("rst_valid", pv4, 0);
      chk("rst_ready", pr4, 0);
      chk("rst_patch", pch4, 0);
      tick();
      rst = 1'b0;
      @(negedge CLK);
      chk("post_rst_valid", pv4, 0);
      chk("post_rst_ready", pr4, 1);
      tick();

      // continuous 4x4 frame, latency checks
      patch_ready = 1'b1;
      for (int v = 0; v < 16; v++) begin
         push(v);
         if (v == 9) chk("lat_none", pv4, 0);
         if (v == 10) begin
            chk("lat_valid", pv4, 1);
            chk("lat_patch", pch4, e[0]);
            chk("lat_last", pl4, 0);
         end
      end
      drain(4);
      check_hand4("s1");

      // output stall for 5 cycles after the first patch
      patch_ready = 1'b0;
      fork
         send_frame(4, 4, 0, 4);
         begin
            int t = 0;
            @(negedge CLK);
            while (!pv4 && t < 200) begin
               @(negedge CLK);
               t++;
            end
            chk("stall_seen", pv4, 1);
            for (int i = 0; i < 5; i++) begin
               chk("stall_patch", pch4, e[0]);
               chk("stall_rdy", pr4, 0);
               if (i < 4) @(negedge CLK);
            end
            tick();
            patch_ready = 1'b1;
         end
      join
      drain(4);
      check_hand4("s2");

      // two back-to-back frames
      send_frame(4, 4, 0, 4);
      send_frame(4, 4, 100, 4);
      drain(8);
      if (qp.size() == 8) begin
         chk("f2_first", qp[4], pk9(100, 101, 102, 104, 105, 106,
                                    108, 109, 110));
         for (int k = 0; k < 8; k++) begin
            chk("bb_patch", qp[k], refp(1 + (k % 4) / 2, 1 + k % 2,
                                        (k < 4) ? 0 : 100, 4));
            chk("bb_last", ql[k], (k == 3 || k == 7));
         end
      end
      qp.delete();
      ql.delete();

      // reset mid-frame after pixel 9
      for (int v = 0; v < 10; v++) push(v);
      chk("pre_rst_none", qp.size(), 0);
      rst = 1'b1;
      @(negedge CLK);
      chk("mid_rst_valid", pv4, 0);
      chk("mid_rst_ready", pr4, 0);
      tick();
      rst = 1'b0;
      send_frame(4, 4, 0, 4);
      drain(4);
      check_hand4("s4");

      // reset with a pending, unaccepted patch
      patch_ready = 1'b0;
      for (int v = 0; v < 11; v++) push(v);
      @(negedge CLK);
      chk("pend_valid", pv4, 1);
      tick();
      rst = 1'b1;
      @(negedge CLK);
      chk("pend_rst_valid", pv4, 0);
      tick();
      rst = 1'b0;
      @(negedge CLK);
      chk("pend_after_valid", pv4, 0);
      chk("pend_after_patch", pch4, 0);
      chk("pend_after_last", pl4, 0);
      patch_ready = 1'b1;
      repeat (3) tick();
      chk("pend_dropped", qp.size(), 0);

      // 8x8 frame with random gaps and random downstream ready
      use8 = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      gap_en = 1'b1;
      rnd_rdy = 1'b1;
      send_frame(8, 8, 0, 16);
      drain(36);
      rnd_rdy = 1'b0;
      gap_en = 1'b0;
      if (qp.size() == 36) begin
         for (int k = 0; k < 36; k++) begin
            chk("rnd_patch", qp[k], refp(1 + k / 6, 1 + k % 6, 0, 16));
            chk("rnd_last", ql[k], (k == 35));
         end
         chk("rnd_w22", qp[35][DW-1:0], 16'h0077);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
